// File: rtl/ball_engine_if.sv
// Raster, paddle and serve inputs plus ball/event outputs of the ball engine.
// The master side drives the raster and control signals; the slave side is the engine.
interface ball_engine_if;
  logic [15:0] h_pos;
  logic [15:0] v_pos;
  logic [9:0]  paddle_x;
  logic        launch;
  logic [9:0]  ball_x;
  logic [9:0]  ball_y;
  logic        pixel_ball;
  logic        frame_tick;
  logic        hit;
  logic        miss;
  logic [1:0]  state;

  modport master (
    output h_pos, v_pos, paddle_x, launch,
    input  ball_x, ball_y, pixel_ball, frame_tick, hit, miss, state
  );

  modport slave (
    input  h_pos, v_pos, paddle_x, launch,
    output ball_x, ball_y, pixel_ball, frame_tick, hit, miss, state
  );
endinterface

// File: rtl/ball_engine.sv
// Pong-style ball: serve/run/miss FSM updated once per frame, wall and paddle
// bounces, and a registered ball-pixel flag for the raster.
module ball_engine #(
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned H_START     = 144,
  parameter int unsigned V_START     = 35,
  parameter int unsigned FIELD_W     = 640,
  parameter int unsigned FIELD_H     = 480,
  parameter int unsigned BALL        = 8,
  parameter int unsigned SPEED       = 2,
  parameter int unsigned PAD_W       = 64,
  parameter int unsigned PAD_Y       = 464,
  parameter int unsigned MISS_FRAMES = 60
) (
  input  logic          clk,
  input  logic          rst_n,
  ball_engine_if.slave  eng
);

  typedef enum logic [1:0] {SERVE = 2'd0, RUN = 2'd1, MISS = 2'd2} state_t;

  localparam logic [9:0] C_X0   = 10'((FIELD_W - BALL) / 2);
  localparam logic [9:0] C_Y0   = 10'((FIELD_H - BALL) / 2);
  localparam logic [9:0] C_XMAX = 10'(FIELD_W - BALL);
  localparam logic [9:0] C_YMAX = 10'(PAD_Y - BALL);
  localparam int unsigned CNT_W = (MISS_FRAMES > 1) ? $clog2(MISS_FRAMES) : 1;

  state_t             r_state;
  logic [9:0]         r_x, r_y;
  logic               r_dx, r_dy;      // 1 = moving right / down
  logic               r_launch;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_pixel, r_frame_tick, r_hit, r_miss;

  logic               w_frame_end, w_bottom, w_overlap, w_pixel;
  logic [9:0]         w_nx, w_ny;
  logic               w_ndx, w_ndy;
  logic [10:0]        w_x_inc, w_y_inc;
  logic [15:0]        w_hrel, w_vrel;

  assign w_frame_end = (eng.h_pos == 16'(H_TOTAL - 1)) && (eng.v_pos == 16'(V_TOTAL - 1));
  assign w_x_inc     = {1'b0, r_x} + 11'(SPEED);
  assign w_y_inc     = {1'b0, r_y} + 11'(SPEED);
  assign w_bottom    = r_dy && (w_y_inc >= {1'b0, C_YMAX});
  assign w_overlap   = ({1'b0, r_x} + 11'(BALL) > {1'b0, eng.paddle_x}) &&
                       ({1'b0, r_x} < {1'b0, eng.paddle_x} + 11'(PAD_W));

  always_comb begin
    w_nx  = r_x;
    w_ndx = r_dx;
    w_ny  = r_y;
    w_ndy = r_dy;
    if (r_dx) begin
      if (w_x_inc >= {1'b0, C_XMAX}) begin
        w_nx  = C_XMAX;
        w_ndx = 1'b0;
      end else begin
        w_nx = w_x_inc[9:0];
      end
    end else if (r_x <= 10'(SPEED)) begin
      w_nx  = '0;
      w_ndx = 1'b1;
    end else begin
      w_nx = r_x - 10'(SPEED);
    end
    if (!r_dy) begin
      if (r_y <= 10'(SPEED)) begin
        w_ny  = '0;
        w_ndy = 1'b1;
      end else begin
        w_ny = r_y - 10'(SPEED);
      end
    end else if (w_bottom) begin
      w_ny  = C_YMAX;
      w_ndy = 1'b0;
    end else begin
      w_ny = w_y_inc[9:0];
    end
  end

  // Relative coordinates are only trusted once the raster is past the start offsets.
  assign w_hrel  = eng.h_pos - 16'(H_START);
  assign w_vrel  = eng.v_pos - 16'(V_START);
  assign w_pixel = (eng.h_pos >= 16'(H_START)) && (eng.v_pos >= 16'(V_START)) &&
                   (w_hrel >= {6'b0, r_x}) && (w_hrel <= {6'b0, r_x} + 16'(BALL - 1)) &&
                   (w_vrel >= {6'b0, r_y}) && (w_vrel <= {6'b0, r_y} + 16'(BALL - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= SERVE;
      r_x          <= C_X0;
      r_y          <= C_Y0;
      r_dx         <= 1'b1;
      r_dy         <= 1'b0;
      r_launch     <= 1'b0;
      r_cnt        <= '0;
      r_pixel      <= 1'b0;
      r_frame_tick <= 1'b0;
      r_hit        <= 1'b0;
      r_miss       <= 1'b0;
    end else begin
      r_frame_tick <= w_frame_end;
      r_pixel      <= w_pixel;
      r_hit        <= 1'b0;
      r_miss       <= 1'b0;
      if ((r_state == SERVE) && eng.launch) r_launch <= 1'b1;
      if (w_frame_end) begin
        case (r_state)
          SERVE: if (r_launch || eng.launch) begin
            r_state  <= RUN;
            r_dx     <= 1'b1;
            r_dy     <= 1'b0;
            r_launch <= 1'b0;
          end
          RUN: if (w_bottom && !w_overlap) begin
            // A miss freezes x; only y snaps to the paddle row.
            r_state <= MISS;
            r_miss  <= 1'b1;
            r_y     <= C_YMAX;
          end else begin
            r_x   <= w_nx;
            r_dx  <= w_ndx;
            r_y   <= w_ny;
            r_dy  <= w_ndy;
            r_hit <= w_bottom;
          end
          MISS: if (r_cnt == CNT_W'(MISS_FRAMES - 1)) begin
            r_state <= SERVE;
            r_cnt   <= '0;
            r_x     <= C_X0;
            r_y     <= C_Y0;
            r_dx    <= 1'b1;
            r_dy    <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
          default: r_state <= SERVE;
        endcase
      end
    end
  end

  assign eng.ball_x     = r_x;
  assign eng.ball_y     = r_y;
  assign eng.pixel_ball = r_pixel;
  assign eng.frame_tick = r_frame_tick;
  assign eng.hit        = r_hit;
  assign eng.miss       = r_miss;
  assign eng.state      = r_state;

endmodule

// File: tb/tb_ball_engine.sv
// Randomised bench for ball_engine against a frame-level behavioural model of the game.
module tb_ball_engine;
  localparam int HT = 800, VT = 525, HS = 144, VS = 35;
  localparam int FW = 640, FH = 480, B = 8, S = 2, PW = 64, PY = 464, MF = 60;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  ball_engine_if bif();

  ball_engine #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_START(HS), .V_START(VS),
    .FIELD_W(FW), .FIELD_H(FH), .BALL(B), .SPEED(S),
    .PAD_W(PW), .PAD_Y(PY), .MISS_FRAMES(MF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .eng(bif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Game model: state 0 serve, 1 run, 2 miss; directions are +1/-1.
  int m_state, m_x, m_y, m_dx, m_dy, m_latch, m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_x = (FW - B) / 2; m_y = (FH - B) / 2;
    m_dx = 1; m_dy = -1; m_latch = 0; m_cnt = 0;
  endtask

  task automatic model_frame(input int pad, output int e_hit, output int e_miss);
    int nx, ndx;
    e_hit = 0; e_miss = 0;
    if (m_state == 0) begin
      if (m_latch != 0) begin
        m_state = 1; m_dx = 1; m_dy = -1; m_latch = 0;
      end
    end else if (m_state == 1) begin
      nx = m_x; ndx = m_dx;
      if (m_dx > 0) begin
        if (m_x + S >= FW - B) begin nx = FW - B; ndx = -1; end
        else nx = m_x + S;
      end else begin
        if (m_x <= S) begin nx = 0; ndx = 1; end
        else nx = m_x - S;
      end
      if (m_dy < 0) begin
        if (m_y <= S) begin m_y = 0; m_dy = 1; end
        else m_y = m_y - S;
      end else if (m_y + S >= PY - B) begin
        m_y = PY - B;
        if (m_x + B > pad && m_x < pad + PW) begin
          m_dy = -1; e_hit = 1;
        end else begin
          m_state = 2; e_miss = 1; nx = m_x; ndx = m_dx;
        end
      end else begin
        m_y = m_y + S;
      end
      m_x = nx; m_dx = ndx;
    end else begin
      m_cnt++;
      if (m_cnt == MF) begin
        model_reset();
      end
    end
  endtask

  task automatic check_outputs(input int e_tick, input int e_hit, input int e_miss, input int e_pix);
    chk("state", bif.state, m_state);
    chk("ball_x", bif.ball_x, m_x);
    chk("ball_y", bif.ball_y, m_y);
    chk("frame_tick", bif.frame_tick, e_tick);
    chk("hit", bif.hit, e_hit);
    chk("miss", bif.miss, e_miss);
    chk("pixel_ball", bif.pixel_ball, e_pix);
  endtask

  // One clock with the given raster position; called #1 after a rising edge.
  task automatic cyc(input int h, input int v, input bit l, input int pad);
    int e_pix, e_hit, e_miss, fe;
    bif.h_pos = 16'(h); bif.v_pos = 16'(v);
    bif.launch = l; bif.paddle_x = 10'(pad);
    fe = (h == HT - 1 && v == VT - 1) ? 1 : 0;
    e_pix = (h >= HS && v >= VS && h - HS >= m_x && h - HS < m_x + B &&
             v - VS >= m_y && v - VS < m_y + B) ? 1 : 0;
    e_hit = 0; e_miss = 0;
    if (l && m_state == 0) m_latch = 1;
    if (fe != 0) model_frame(pad, e_hit, e_miss);
    @(posedge clk); #1;
    check_outputs(fe, e_hit, e_miss, e_pix);
  endtask

  // Asynchronous reset asserted between edges; outputs must settle without a clock.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs(0, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  function automatic int rand_h();
    if ($urandom_range(1) == 0) return HS + m_x - 10 + int'($urandom_range(22));
    return int'($urandom_range(HT - 1));
  endfunction

  function automatic int rand_v();
    if ($urandom_range(1) == 0) return VS + m_y - 10 + int'($urandom_range(22));
    return int'($urandom_range(VT - 2));
  endfunction

  initial begin
    int pad;
    bif.h_pos = '0; bif.v_pos = '0; bif.paddle_x = '0; bif.launch = 1'b0;
    model_reset();
    do_reset();

    // Serve launched from line 100, then two frames of motion.
    cyc(300, 100, 1'b1, 0);
    cyc(301, 100, 1'b0, 0);
    cyc(HT - 1, VT - 1, 1'b0, 0);
    chk("launch_to_run", bif.state, 1);
    cyc(10, 10, 1'b0, 0);
    cyc(HT - 1, VT - 1, 1'b0, 0);
    chk("first_move_x", bif.ball_x, 318);
    chk("first_move_y", bif.ball_y, 234);

    for (int f = 0; f < 2500; f++) begin
      if ($urandom_range(99) < 75) pad = m_x - 63 + int'($urandom_range(70));
      else pad = int'($urandom_range(1023));
      if (pad < 0) pad = 0;
      for (int k = 0; k < 3; k++)
        cyc(rand_h(), rand_v(), ($urandom_range(19) == 0), pad);
      cyc(HT - 1, VT - 1, 1'b0, pad);
      if (f == 1200 || $urandom_range(999) == 0) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
